// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL output stage: RTO word layout, default
// counter width and the timestamp type.
package ttl_pkg;

  localparam int RTO_TS_MSB    = 127;
  localparam int RTO_TS_LSB    = 64;
  localparam int CNT_W_DEFAULT = 32;

  typedef logic [63:0] ts_t;

endpackage

// File: rtl/ttl_edge_counter.sv
// Saturating rising-edge counter for one TTL pin. It looks at the pin register's
// current and next value, so the count moves on the same edge the pin rises.
module ttl_edge_counter
  import ttl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             pin_q,
  input  logic             pin_d,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A clear wins over a coincident edge; a full counter sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (pin_d && !pin_q && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/ttl_out_stage.sv
// TTL output stage behind the RTO core: registers matched levels, applies
// override and inversion, checks minimum hold time and counts pin edges.
module ttl_out_stage
  import ttl_pkg::*;
#(
  parameter int NUM_CH   = 1,
  parameter int MIN_HOLD = 4,
  parameter int CNT_W    = CNT_W_DEFAULT,
  localparam int SEL_W   = $clog2(NUM_CH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              match_valid,
  input  logic [127:0]      rto_data,
  input  logic [NUM_CH-1:0] override_en,
  input  logic [NUM_CH-1:0] override_val,
  input  logic [NUM_CH-1:0] invert,
  input  logic              cnt_clr,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic [NUM_CH-1:0] ttl_out,
  output logic [CNT_W-1:0]  cnt_out,
  output ts_t               last_ts,
  output logic              hold_violation,
  output logic [NUM_CH-1:0] viol_ch
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_OK  = HOLD_W'(MIN_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [NUM_CH-1:0]             level;
  logic [NUM_CH-1:0]             level_next;
  logic [NUM_CH-1:0]             changed;
  logic [NUM_CH-1:0]             viol_now;
  logic [NUM_CH-1:0]             pin_next;
  logic [NUM_CH-1:0][HOLD_W-1:0] hold;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]              sel_cnt;
  logic                          cnt_clear;
  logic                          unused_data;

  assign unused_data = ^rto_data[63:NUM_CH];
  assign cnt_clear   = flush | cnt_clr;

  // hold[i] counts whole cycles since level[i] last changed; the cycle holding
  // the new match also counts, so a change is legal once hold reaches MIN_HOLD-1.
  always_comb begin
    level_next = match_valid ? rto_data[NUM_CH-1:0] : level;
    changed    = level_next ^ level;
    pin_next   = ((override_en & override_val) | (~override_en & level_next)) ^ invert;
    viol_now   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      viol_now[i] = changed[i] && (hold[i] < HOLD_OK);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level          <= '0;
      ttl_out        <= '0;
      last_ts        <= '0;
      viol_ch        <= '0;
      hold_violation <= 1'b0;
    end else if (flush) begin
      level          <= '0;
      ttl_out        <= '0;
      last_ts        <= '0;
      viol_ch        <= '0;
      hold_violation <= 1'b0;
    end else begin
      level          <= level_next;
      ttl_out        <= pin_next;
      viol_ch        <= viol_ch | viol_now;
      hold_violation <= hold_violation | (|viol_now);
      if (match_valid) begin
        last_ts <= rto_data[RTO_TS_MSB:RTO_TS_LSB];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= {NUM_CH{HOLD_MAX}};
    end else if (flush) begin
      hold <= {NUM_CH{HOLD_MAX}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (changed[i]) begin
          hold[i] <= '0;
        end else if (hold[i] != HOLD_MAX) begin
          hold[i] <= hold[i] + HOLD_ONE;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    ttl_edge_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (cnt_clear),
      .pin_q(ttl_out[g]),
      .pin_d(pin_next[g]),
      .cnt  (cnt[g])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        sel_cnt = cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_out <= '0;
    end else if (flush) begin
      cnt_out <= '0;
    end else begin
      cnt_out <= sel_cnt;
    end
  end

endmodule
